// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry pipeline skid register with registered valid/ready and flush
module pipe_skid_reg #(
  parameter int              N         = 32,
  parameter logic [N-1:0]    RESET_VAL = '0,
  parameter logic [N-1:0]    FLUSH_VAL = N'(32'h00000013)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [N-1:0] main_q;
  logic [N-1:0] skid_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         in_xfer;
  logic         out_xfer;

  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = state;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_xfer) state_nxt = ONE;
      ONE: begin
        if (in_xfer && !out_xfer)      state_nxt = FULL;
        else if (!in_xfer && out_xfer) state_nxt = EMPTY;
      end
      FULL:    if (out_xfer) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // Handshake flags are precomputed from the next state so both stay pure flop outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
      if (flush) begin
        main_q <= FLUSH_VAL;
      end else begin
        case (state)
          EMPTY: if (in_xfer) main_q <= in_data;
          ONE: begin
            if (in_xfer && out_xfer) main_q <= in_data;
            else if (in_xfer)        skid_q <= in_data;
          end
          FULL:    if (out_xfer) main_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed vector table plus random scoreboard run for pipe_skid_reg
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(.N(32), .RESET_VAL(32'h0), .FLUSH_VAL(32'h00000013)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic [1:0]  ecnt;
    logic        eir;
    logic        eov;
    logic [31:0] eod;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic fl, input logic iv, input logic [31:0] id,
                     input logic ordy, input logic [1:0] ecnt, input logic eir, input logic eov,
                     input logic [31:0] eod);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ecnt = ecnt; v.eir = eir; v.eov = eov; v.eod = eod;
    vecs.push_back(v);
  endtask

  logic [31:0] model_q[$];
  logic        ir_before, ov_before, do_in, do_out, do_flush;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //   rst fl iv data          ordy cnt ir ov out_data
    add(1, 0, 0, 32'h0,        0, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 32'h0);
    add(0, 0, 1, 32'h11,       1, 1, 1, 1, 32'h11);
    add(0, 0, 1, 32'h22,       1, 1, 1, 1, 32'h22);
    add(0, 0, 1, 32'h33,       1, 1, 1, 1, 32'h33);
    add(0, 0, 0, 32'h0,        1, 0, 1, 0, 32'h33);
    add(0, 0, 1, 32'hA1,       0, 1, 1, 1, 32'hA1);
    add(0, 0, 1, 32'hA2,       0, 2, 0, 1, 32'hA1);
    add(0, 0, 0, 32'h0,        0, 2, 0, 1, 32'hA1);
    add(0, 0, 1, 32'hC0,       0, 2, 0, 1, 32'hA1);
    add(0, 0, 0, 32'h0,        1, 1, 1, 1, 32'hA2);
    add(0, 0, 0, 32'h0,        1, 0, 1, 0, 32'hA2);
    add(0, 0, 1, 32'hB1,       0, 1, 1, 1, 32'hB1);
    add(0, 0, 1, 32'hB2,       0, 2, 0, 1, 32'hB1);
    add(0, 1, 1, 32'hBB,       0, 0, 1, 0, 32'h13);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 32'h13);
    add(0, 0, 1, 32'hC1,       0, 1, 1, 1, 32'hC1);
    add(0, 1, 1, 32'hC2,       1, 0, 1, 0, 32'h13);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 32'h13);
    add(0, 0, 1, 32'hD1,       0, 1, 1, 1, 32'hD1);
    add(0, 0, 1, 32'hD2,       0, 2, 0, 1, 32'hD1);
    add(1, 1, 1, 32'hDD,       1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 1, 0, 32'h0);
    add(0, 0, 1, 32'hE1,       0, 1, 1, 1, 32'hE1);
    add(0, 0, 1, 32'hE2,       1, 1, 1, 1, 32'hE2);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; flush = vecs[i].fl; in_valid = vecs[i].iv;
      in_data = vecs[i].id; out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      check("count",     i, 32'(count),     32'(vecs[i].ecnt));
      check("in_ready",  i, 32'(in_ready),  32'(vecs[i].eir));
      check("out_valid", i, 32'(out_valid), 32'(vecs[i].eov));
      check("out_data",  i, out_data,       vecs[i].eod);
    end

    // Drain the directed leftovers, then run a random stream against a queue model.
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();

    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      check("rnd_count", c, 32'(count), 32'(model_q.size()));
      check("rnd_in_ready", c, 32'(in_ready), 32'(model_q.size() < 2));
      check("rnd_out_valid", c, 32'(out_valid), 32'(model_q.size() > 0));
      if (model_q.size() > 0) check("rnd_out_data", c, out_data, model_q[0]);
      ir_before = in_ready;
      ov_before = out_valid;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      #1;
      check("comb_in_ready", c, 32'(in_ready), 32'(ir_before));
      check("comb_out_valid", c, 32'(out_valid), 32'(ov_before));
      do_in    = in_valid && (model_q.size() < 2);
      do_out   = out_ready && (model_q.size() > 0);
      do_flush = flush;
      @(posedge clk);
      if (do_out) void'(model_q.pop_front());
      if (do_in)  model_q.push_back(in_data);
      if (do_flush) model_q.delete();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL provide parameter N, default 32: data width in bits, legal range 1..64.
REQ-002 SHALL provide parameter RESET_VAL, default 0: value of out_data and of both storage entries after reset.
REQ-003 SHALL provide parameter FLUSH_VAL, default 32'h00000013: value loaded into out_data on flush (RV32I NOP).
REQ-004 SHALL provide port clk  input  1: clock; all state updates on the rising edge.
REQ-005 SHALL provide port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL provide port flush  input  1: discard all held entries.
REQ-007 SHALL provide port in_valid  input  1: upstream data valid.
REQ-008 SHALL provide port in_data  input  N: upstream data.
REQ-009 SHALL provide port in_ready  output  1: block can accept; driven directly from a register.
REQ-010 SHALL provide port out_valid  output  1: out_data valid; driven directly from a register.
REQ-011 SHALL provide port out_data  output  N: head entry; driven directly from a register.
REQ-012 SHALL provide port out_ready  input  1: downstream accepts.
REQ-013 SHALL provide port count  output  2: entries held, 0..2.

Function
REQ-014 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; output transfer SHALL occur with out_valid=1 and out_ready=1.
REQ-015 Storage SHALL be two entries: a main register driving out_data and a skid register.
REQ-016 The state machine SHALL have states EMPTY (count=0), ONE (count=1), FULL (count=2).
REQ-017 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; out_valid SHALL be 1 in ONE and FULL.
REQ-018 In EMPTY, an input transfer SHALL load main and move to ONE; otherwise the block SHALL stay in EMPTY.
REQ-019 In ONE, input and output transfers in the same cycle SHALL load main and stay in ONE.
REQ-020 In ONE, an input transfer with no output transfer SHALL load skid and move to FULL; main SHALL be unchanged.
REQ-021 In ONE, an output transfer with no input transfer SHALL move to EMPTY.
REQ-022 In FULL, an output transfer SHALL copy skid to main and move to ONE; otherwise the block SHALL stay in FULL.
REQ-023 When the block moves to EMPTY without flush, main SHALL retain its last value.
REQ-024 Data SHALL leave in arrival order with no duplication and no loss (except on flush).
REQ-025 Latency SHALL be 1 cycle from an input transfer into EMPTY to out_valid=1 with that data.
REQ-026 With out_ready held at 1, throughput SHALL be one transfer per cycle.
REQ-027 out_data SHALL stay stable while out_valid=1 and out_ready=0, except on flush.
REQ-028 No combinational path SHALL exist from out_ready or in_valid to in_ready or out_valid.
REQ-029 flush=1 SHALL have priority over all transfers:
  - next state EMPTY, count=0
  - out_data <= FLUSH_VAL
  - any same-cycle input transfer (in_ready was 1) SHALL be accepted and dropped.
REQ-030 An output transfer in a flush cycle SHALL be valid downstream; the entry SHALL then be removed by the flush.
REQ-031 count SHALL be a registered output matching the state encoding.

Reset
REQ-032 While reset=1 at a rising edge, the block SHALL set state EMPTY, out_valid=0, in_ready=1, count=0, and main and skid to RESET_VAL.
REQ-033 reset SHALL have priority over flush and over all transfers, including reset asserted mid-operation in FULL.
REQ-034 Outputs SHALL be defined from the first edge with reset=1; no power-on initial value SHALL be relied on.

Verification
REQ-035 Reset then idle: count=0, out_valid=0, in_ready=1, out_data=0.
REQ-036 Stream 0x11,0x22,0x33 with out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after its input; count stays 1.
REQ-037 Backpressure: out_ready=0, push 0xA1 then 0xA2 -> count=2, in_ready=0, out_data=0xA1; set out_ready=1 -> 0xA1 then 0xA2 out, in_ready=1 one cycle after the first pop.
REQ-038 FULL plus flush=1 with in_valid=1 (data 0xBB) -> next cycle count=0, out_valid=0, out_data=0x00000013; 0xBB never appears.
REQ-039 reset=1 and flush=1 together in FULL -> out_data=RESET_VAL, count=0.
REQ-040 Random valid/ready stimulus over 10k cycles -> scoreboard matches order and content; in_ready and out_valid never change combinationally.
